// File: rtl/math_pkg.sv
// Shared definitions for the Math streaming primitives: reducer state encoding,
// count sizing and FP format helpers.
package math_pkg;

   typedef enum logic {ST_ACCUM, ST_EMIT} red_state_e;

   localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
   localparam logic [63:0] FP64_ZERO = 64'h0000_0000_0000_0000;

   function automatic int count_width(input int max_len);
      return $clog2(max_len + 1);
   endfunction

   function automatic int fp_exp_bits(input int width);
      return (width == 64) ? 11 : 8;
   endfunction

endpackage

// File: rtl/math_fadd.sv
// Combinational IEEE-754 add, round-to-nearest-even, for binary32 or binary64.
// NaN results are the canonical quiet NaN; subnormals are handled fully.
module math_fadd
   import math_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result
);

   localparam int EW   = fp_exp_bits(WIDTH);
   localparam int FW   = WIDTH - 1 - EW;
   localparam int MW   = FW + 1;
   localparam int XW   = MW + 3;
   localparam int EMAX = (1 << EW) - 1;

   if (WIDTH == 32 || WIDTH == 64) begin : g_fadd
      logic             a_nan, b_nan, a_inf, b_inf, swap, sgn, sticky, rnd;
      logic [WIDTH-1:0] big, sml;
      logic [XW-1:0]    big_x, sml_x, sml_sh, m;
      logic [XW:0]      s;
      logic [MW:0]      mr;
      int               eb, es, d, e, lz, sh;

      always_comb begin
         a_nan = (a[WIDTH-2:FW] == EW'(EMAX)) && (a[FW-1:0] != '0);
         b_nan = (b[WIDTH-2:FW] == EW'(EMAX)) && (b[FW-1:0] != '0);
         a_inf = (a[WIDTH-2:FW] == EW'(EMAX)) && (a[FW-1:0] == '0);
         b_inf = (b[WIDTH-2:FW] == EW'(EMAX)) && (b[FW-1:0] == '0);

         // Order operands by magnitude so the difference below is never negative.
         swap  = b[WIDTH-2:0] > a[WIDTH-2:0];
         big   = swap ? b : a;
         sml   = swap ? a : b;
         sgn   = big[WIDTH-1];
         eb    = (big[WIDTH-2:FW] == '0) ? 1 : int'(big[WIDTH-2:FW]);
         es    = (sml[WIDTH-2:FW] == '0) ? 1 : int'(sml[WIDTH-2:FW]);
         big_x = {big[WIDTH-2:FW] != '0, big[FW-1:0], 3'b000};
         sml_x = {sml[WIDTH-2:FW] != '0, sml[FW-1:0], 3'b000};
         d     = eb - es;

         if (d >= XW) begin
            sml_sh = '0;
            sticky = |sml_x;
         end else begin
            sml_sh = sml_x >> d;
            sticky = |(sml_x & ~({XW{1'b1}} << d));
         end
         sml_sh[0] = sml_sh[0] | sticky;

         if (big[WIDTH-1] == sml[WIDTH-1]) s = {1'b0, big_x} + {1'b0, sml_sh};
         else                              s = {1'b0, big_x} - {1'b0, sml_sh};

         m  = s[XW-1:0];
         e  = eb;
         lz = 0;
         sh = 0;
         if (s[XW]) begin
            m = {s[XW:2], s[1] | s[0]};
            e = eb + 1;
         end else begin
            lz = XW;
            for (int i = 0; i < XW; i++) begin
               if (m[i]) lz = XW - 1 - i;
            end
            // Never normalise below the minimum exponent; that leaves a subnormal.
            sh = (lz < e - 1) ? lz : e - 1;
            m  = m << sh;
            e  = e - sh;
         end

         rnd = m[2] & (m[1] | m[0] | m[3]);
         mr  = {1'b0, m[XW-1:3]} + {{MW{1'b0}}, rnd};
         if (mr[MW]) begin
            mr = mr >> 1;
            e  = e + 1;
         end

         result = {sgn, (mr[MW-1] ? EW'(e) : EW'(0)), mr[FW-1:0]};
         if (e >= EMAX) result = {sgn, EW'(EMAX), FW'(0)};
         if (s == '0)   result = {a[WIDTH-1] & b[WIDTH-1], (WIDTH-1)'(0)};
         if (a_inf)     result = a;
         if (b_inf)     result = b;
         if (a_nan || b_nan || (a_inf && b_inf && (a[WIDTH-1] != b[WIDTH-1])))
            result = {1'b0, EW'(EMAX), 1'b1, (FW-1)'(0)};
      end
   end else begin : g_bad
      $fatal(1, "math_fadd: WIDTH must be 32 or 64");
      assign result = '0;
   end

endmodule

// File: rtl/math_exp_sum_reduce.sv
// Streaming reducer: sums a vector of exp() results in arrival order and emits one
// sum plus element count per vector (softmax denominator).
//
//   state    | meaning
//   ST_ACCUM | accepting elements, accumulating partial sum
//   ST_EMIT  | result presented, waiting for out_ready
module math_exp_sum_reduce
   import math_pkg::*;
#(
   parameter  int WIDTH   = 32,
   parameter  int MAX_LEN = 1024,
   localparam int CW      = count_width(MAX_LEN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic [CW-1:0]    out_count,
   output logic             out_ovf
);

   localparam logic [WIDTH-1:0] FP_ZERO = (WIDTH == 64) ? WIDTH'(FP64_ZERO) : WIDTH'(FP32_ZERO);
   localparam logic [CW-1:0]    CNT_MAX = CW'(MAX_LEN);

   red_state_e       state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d, out_sum_q, out_sum_d, nsum;
   logic [CW-1:0]    cnt_q, cnt_d, out_count_q, out_count_d, cnt_next;
   logic             ovf_q, ovf_d, out_ovf_q, out_ovf_d, out_valid_q, out_valid_d;
   logic             ovf_next, accept;

   math_fadd #(.WIDTH(WIDTH)) u_fadd (
      .a      (acc_q),
      .b      (in_data),
      .result (nsum)
   );

   assign in_ready = (state_q == ST_ACCUM);
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_count_d = out_count_q;
      out_ovf_d   = out_ovf_q;
      cnt_next    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
      ovf_next    = ovf_q | (cnt_q == CNT_MAX);

      case (state_q)
         ST_ACCUM: begin
            if (accept) begin
               if (!in_last) begin
                  acc_d = nsum;
                  cnt_d = cnt_next;
                  ovf_d = ovf_next;
               end else begin
                  out_sum_d   = nsum;
                  out_count_d = cnt_next;
                  out_ovf_d   = ovf_next;
                  out_valid_d = 1'b1;
                  acc_d       = FP_ZERO;
                  cnt_d       = '0;
                  ovf_d       = 1'b0;
                  state_d     = ST_EMIT;
               end
            end
         end
         ST_EMIT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_ACCUM;
            end
         end
         default: state_d = ST_ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_ACCUM;
         acc_q       <= FP_ZERO;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_count_q <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_count_q <= out_count_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_count = out_count_q;
   assign out_ovf   = out_ovf_q;

endmodule
